// File: rtl/cpu_pkg.sv
// Shared opcode fields, register/source codes and the decoded control vector
// for the nibble processor front end.
package cpu_pkg;

  localparam logic       OP_LOAD = 1'b0;     // ir[7]
  localparam logic [1:0] OP_MOVE = 2'b10;    // ir[7:6]
  localparam logic [2:0] OP_ALU  = 3'b110;   // ir[7:5]
  localparam logic [3:0] OP_JMP  = 4'b1110;  // ir[7:4]
  localparam logic [3:0] OP_JNZ  = 4'b1111;  // ir[7:4]

  // destination and source codes share one numbering
  localparam logic [2:0] D_X0 = 3'd0;
  localparam logic [2:0] D_X1 = 3'd1;
  localparam logic [2:0] D_Y0 = 3'd2;
  localparam logic [2:0] D_Y1 = 3'd3;
  localparam logic [2:0] D_O  = 3'd4;
  localparam logic [2:0] D_M  = 3'd5;
  localparam logic [2:0] D_I  = 3'd6;
  localparam logic [2:0] D_DM = 3'd7;

  localparam logic [3:0] SS_PM    = 4'd8;
  localparam logic [3:0] SS_IPINS = 4'd9;

  localparam int RE_X0 = 0;
  localparam int RE_X1 = 1;
  localparam int RE_Y0 = 2;
  localparam int RE_Y1 = 3;
  localparam int RE_R  = 4;
  localparam int RE_M  = 5;
  localparam int RE_I  = 6;
  localparam int RE_DM = 7;
  localparam int RE_O  = 8;

  localparam logic [7:0] ALT_TOGGLE = 8'hBF;

  typedef struct packed {
    logic [3:0] source_sel;
    logic [8:0] reg_en;
    logic       i_sel;
    logic       x_sel;
    logic       y_sel;
  } ctrl_t;

  function automatic logic [8:0] dest_en(input logic [2:0] d);
    logic [8:0] en;
    en = '0;
    case (d)
      D_X0:    en[RE_X0] = 1'b1;
      D_X1:    en[RE_X1] = 1'b1;
      D_Y0:    en[RE_Y0] = 1'b1;
      D_Y1:    en[RE_Y1] = 1'b1;
      D_O:     en[RE_O]  = 1'b1;
      D_M:     en[RE_M]  = 1'b1;
      D_I:     en[RE_I]  = 1'b1;
      default: en[RE_DM] = 1'b1;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decode: instruction register to computational
// unit control vector. A bubble (ir_valid_i=0) produces no enables.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [7:0] ir_i,
  input  logic       ir_valid_i,
  output ctrl_t      ctrl_o
);

  logic [2:0] d;
  logic [2:0] s;

  always_comb begin
    ctrl_o = '0;
    d      = ir_i[6:4];
    s      = ir_i[2:0];
    if (ir_valid_i) begin
      if (ir_i[7] == OP_LOAD) begin
        ctrl_o.source_sel = SS_PM;
        ctrl_o.reg_en     = dest_en(d);
        if (d == D_DM) begin
          ctrl_o.reg_en[RE_I] = 1'b1;
          ctrl_o.i_sel        = 1'b1;
        end
      end else if (ir_i[7:6] == OP_MOVE) begin
        d                 = ir_i[5:3];
        ctrl_o.source_sel = {1'b0, s};
        // 8'hBF only flips alt in the sequencer; it writes nothing here
        if (ir_i != ALT_TOGGLE) begin
          if (s == d)
            ctrl_o.source_sel = SS_IPINS;
          ctrl_o.reg_en = dest_en(d);
          // a data_bus write into i takes priority over post-increment
          if ((d == D_DM || s == D_DM) && d != D_I) begin
            ctrl_o.reg_en[RE_I] = 1'b1;
            ctrl_o.i_sel        = 1'b1;
          end
        end
      end else if (ir_i[7:5] == OP_ALU) begin
        ctrl_o.x_sel        = ir_i[4];
        ctrl_o.y_sel        = ir_i[3];
        ctrl_o.reg_en[RE_R] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_decoder_sequencer.sv
// Fetch/sequence front end: program counter, one-deep instruction register
// with jump bubbles, alternate-mode flag, and forced controls during reset.
module instr_decoder_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            sync_reset,
  input  logic [7:0]      pm_data,
  input  logic            r_eq_0,
  output logic [PC_W-1:0] pm_addr,
  output logic [3:0]      ir_nibble,
  output logic [3:0]      source_sel,
  output logic [8:0]      reg_en,
  output logic            i_sel,
  output logic            x_sel,
  output logic            y_sel,
  output logic            alternate_function
);

  typedef enum logic {BUBBLE = 1'b0, RUN = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic            alt_q, alt_d;
  ctrl_t           ctrl;

  always_comb begin
    pc_d    = pc_q + PC_W'(1);
    ir_d    = pm_data;
    state_d = RUN;
    alt_d   = alt_q;
    if (state_q == RUN) begin
      // pm_data currently holds the jump target byte
      if (ir_q[7:4] == OP_JMP || (ir_q[7:4] == OP_JNZ && !r_eq_0)) begin
        pc_d    = PC_W'(pm_data);
        state_d = BUBBLE;
      end else if (ir_q[7:4] == OP_JNZ) begin
        state_d = BUBBLE;
      end
      if (ir_q == ALT_TOGGLE)
        alt_d = ~alt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      state_q <= BUBBLE;
      alt_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      state_q <= state_d;
      alt_q   <= alt_d;
    end
  end

  instr_decode u_decode (
    .ir_i       (ir_q),
    .ir_valid_i (state_q == RUN),
    .ctrl_o     (ctrl)
  );

  // reset forces r to load so the computational unit clears r and sets r_eq_0
  assign pm_addr            = pc_q;
  assign ir_nibble          = sync_reset ? 4'h0 : ir_q[3:0];
  assign source_sel         = sync_reset ? 4'h0 : ctrl.source_sel;
  assign reg_en             = sync_reset ? 9'h010 : ctrl.reg_en;
  assign i_sel              = sync_reset ? 1'b0 : ctrl.i_sel;
  assign x_sel              = sync_reset ? 1'b0 : ctrl.x_sel;
  assign y_sel              = sync_reset ? 1'b0 : ctrl.y_sel;
  assign alternate_function = sync_reset ? 1'b0 : alt_q;

endmodule

// File: tb/tb_instr_decoder_sequencer.sv
// Directed bench: expected control vectors are queued per step and compared
// against the DUT outputs on the falling edge.
module tb_instr_decoder_sequencer;

  typedef struct packed {
    logic [7:0] pc;
    logic [3:0] ss;
    logic [8:0] re;
    logic       is;
    logic       xs;
    logic       ys;
    logic       alt;
    logic [3:0] nib;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  val;
    obs_t  msk;
  } exp_t;

  logic       clk = 1'b0;
  logic       sync_reset;
  logic [7:0] pm_data;
  logic       r_eq_0;
  logic [7:0] pm_addr;
  logic [3:0] ir_nibble, source_sel;
  logic [8:0] reg_en;
  logic       i_sel, x_sel, y_sel, alternate_function;

  logic [7:0] pm [256];
  exp_t       sb_q[$];
  int         checks = 0;
  int         failures = 0;
  obs_t       m_all, m_noss, m_ctl;

  always #5 clk = ~clk;
  assign pm_data = pm[pm_addr];

  instr_decoder_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk                (clk),
    .sync_reset         (sync_reset),
    .pm_data            (pm_data),
    .r_eq_0             (r_eq_0),
    .pm_addr            (pm_addr),
    .ir_nibble          (ir_nibble),
    .source_sel         (source_sel),
    .reg_en             (reg_en),
    .i_sel              (i_sel),
    .x_sel              (x_sel),
    .y_sel              (y_sel),
    .alternate_function (alternate_function)
  );

  function automatic obs_t mk(input logic [7:0] pc, input logic [3:0] ss,
                              input logic [8:0] re, input logic is,
                              input logic xs, input logic ys,
                              input logic alt, input logic [3:0] nib);
    return {pc, ss, re, is, xs, ys, alt, nib};
  endfunction

  task automatic push(input string tag, input obs_t val, input obs_t msk);
    exp_t e;
    e.tag = tag;
    e.val = val;
    e.msk = msk;
    sb_q.push_back(e);
  endtask

  // one edge, then compare everything queued against the settled outputs
  task automatic step_check();
    exp_t e;
    obs_t act;
    @(negedge clk);
    act = {pm_addr, source_sel, reg_en, i_sel, x_sel, y_sel,
           alternate_function, ir_nibble};
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      assert ((act & e.msk) === (e.val & e.msk))
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h mask=%h", e.tag, act, e.val, e.msk);
      end
    end
  endtask

  initial begin
    m_all  = '1;
    m_noss = mk(8'hFF, 4'h0, 9'h1FF, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF);
    m_ctl  = mk(8'hFF, 4'hF, 9'h1FF, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
    for (int i = 0; i < 256; i++) pm[i] = 8'h00;
    pm[8'h00] = 8'h35; pm[8'h01] = 8'h81; pm[8'h02] = 8'h80; pm[8'h03] = 8'h87;
    pm[8'h04] = 8'hB7; pm[8'h05] = 8'hD9; pm[8'h06] = 8'hBF; pm[8'h07] = 8'h00;
    pm[8'h08] = 8'hBF; pm[8'h09] = 8'h00; pm[8'h0A] = 8'hE0; pm[8'h0B] = 8'h40;
    pm[8'h40] = 8'h12; pm[8'h41] = 8'hE0; pm[8'h42] = 8'h14;
    pm[8'h14] = 8'hF0; pm[8'h15] = 8'h80;
    pm[8'h80] = 8'hE0; pm[8'h81] = 8'h14;
    pm[8'h16] = 8'h70; pm[8'h17] = 8'hF0; pm[8'h18] = 8'h90;
    pm[8'h90] = 8'h55;

    sync_reset = 1'b1;
    r_eq_0     = 1'b0;
    repeat (2) @(posedge clk);
    push("reset", mk(8'h00, 4'h0, 9'h010, 0, 0, 0, 0, 4'h0), m_all);
    step_check();
    sync_reset = 1'b0;

    push("load_y1", mk(8'h01, 4'h8, 9'h008, 0, 0, 0, 0, 4'h5), m_all);
    step_check();
    push("mv_x0_x1", mk(8'h02, 4'h1, 9'h001, 0, 0, 0, 0, 4'h1), m_all);
    step_check();
    push("mv_ipins", mk(8'h03, 4'h9, 9'h001, 0, 0, 0, 0, 4'h0), m_all);
    step_check();
    push("mv_x0_dm", mk(8'h04, 4'h7, 9'h041, 1, 0, 0, 0, 4'h7), m_all);
    step_check();
    push("mv_i_dm", mk(8'h05, 4'h7, 9'h040, 0, 0, 0, 0, 4'h7), m_all);
    step_check();
    push("alu_d9", mk(8'h06, 4'h0, 9'h010, 0, 1, 1, 0, 4'h9), m_noss);
    step_check();
    push("alt_tog1", mk(8'h07, 4'h0, 9'h000, 0, 0, 0, 0, 4'hF), m_noss);
    step_check();
    push("alt_on", mk(8'h08, 4'h8, 9'h001, 0, 0, 0, 1, 4'h0), m_all);
    step_check();
    push("alt_tog2", mk(8'h09, 4'h0, 9'h000, 0, 0, 0, 1, 4'hF), m_noss);
    step_check();
    push("alt_off", mk(8'h0A, 4'h8, 9'h001, 0, 0, 0, 0, 4'h0), m_all);
    step_check();
    push("jmp_ir", mk(8'h0B, 4'h0, 9'h000, 0, 0, 0, 0, 4'h0), m_noss & m_ctl);
    step_check();
    push("jmp_bubble", mk(8'h40, 4'h0, 9'h000, 0, 0, 0, 0, 4'h0), m_ctl);
    step_check();
    push("jmp_target", mk(8'h41, 4'h8, 9'h002, 0, 0, 0, 0, 4'h2), m_all);
    step_check();
    push("jmp2_ir", mk(8'h42, 4'h0, 9'h000, 0, 0, 0, 0, 4'h0), m_noss & m_ctl);
    step_check();
    push("jmp2_bubble", mk(8'h14, 4'h0, 9'h000, 0, 0, 0, 0, 4'h0), m_ctl);
    step_check();
    push("jnz_ir", mk(8'h15, 4'h0, 9'h000, 0, 0, 0, 0, 4'h0), m_noss & m_ctl);
    step_check();
    push("jnz_taken", mk(8'h80, 4'h0, 9'h000, 0, 0, 0, 0, 4'h0), m_ctl);
    step_check();
    push("jmp3_ir", mk(8'h81, 4'h0, 9'h000, 0, 0, 0, 0, 4'h0), m_noss & m_ctl);
    step_check();
    push("jmp3_bubble", mk(8'h14, 4'h0, 9'h000, 0, 0, 0, 0, 4'h0), m_ctl);
    step_check();
    r_eq_0 = 1'b1;
    push("jnz2_ir", mk(8'h15, 4'h0, 9'h000, 0, 0, 0, 0, 4'h0), m_noss & m_ctl);
    step_check();
    push("jnz_not_taken", mk(8'h16, 4'h0, 9'h000, 0, 0, 0, 0, 4'h0), m_ctl);
    step_check();
    r_eq_0 = 1'b0;
    push("load_dm", mk(8'h17, 4'h8, 9'h0C0, 1, 0, 0, 0, 4'h0), m_all);
    step_check();
    push("jnz3_ir", mk(8'h18, 4'h0, 9'h000, 0, 0, 0, 0, 4'h0), m_noss & m_ctl);
    step_check();
    push("jnz3_bubble", mk(8'h90, 4'h0, 9'h000, 0, 0, 0, 0, 4'h0), m_ctl);
    step_check();
    sync_reset = 1'b1;
    push("reset_in_bubble", mk(8'h00, 4'h0, 9'h010, 0, 0, 0, 0, 4'h0), m_all);
    step_check();
    sync_reset = 1'b0;
    push("reset_recover_bubble", mk(8'h00, 4'h0, 9'h000, 0, 0, 0, 0, 4'h0), m_ctl);
    #1;
    step_check_now();
    push("reset_refetch", mk(8'h01, 4'h8, 9'h008, 0, 0, 0, 0, 4'h5), m_all);
    step_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // compare without advancing the clock (used right after reset release)
  task automatic step_check_now();
    exp_t e;
    obs_t act;
    act = {pm_addr, source_sel, reg_en, i_sel, x_sel, y_sel,
           alternate_function, ir_nibble};
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      assert ((act & e.msk) === (e.val & e.msk))
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h mask=%h", e.tag, act, e.val, e.msk);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_decoder_sequencer.md
Name: instr_decoder_sequencer

Overview:
- Front end of the 4-bit nibble processor: fetches 8-bit instructions from program memory and decodes them.
- Drives every control input of the computational unit: source_sel, reg_en, i_sel, x_sel, y_sel, ir_nibble, alternate_function.
- Consumes r_eq_0 back from the computational unit for conditional jumps.
- Owns the program counter and a one-deep instruction register with bubble/flush control.

Parameters:
- PC_W, 8, program counter and pm_addr width.
- RESET_PC, 8'h00, pc value loaded on sync_reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- sync_reset  in  1  synchronous, active-high reset.
- pm_data  in  8  program memory read data; combinational from pm_addr.
- r_eq_0  in  1  zero flag from the computational unit.
- pm_addr  out  PC_W  program memory address; equals pc.
- ir_nibble  out  4  ir[3:0]; immediate data or ALU function.
- source_sel  out  4  data bus source select.
- reg_en  out  9  register enables. Bits 0–3: x0, x1, y0, y1. Bit 4: r. Bit 5: m. Bit 6: i. Bit 7: dm write. Bit 8: o_reg.
- i_sel  out  1  0 = i loads from data_bus; 1 = i <= i+m.
- x_sel  out  1  ALU x operand select.
- y_sel  out  1  ALU y operand select.
- alternate_function  out  1  sticky ALU alternate mode.

Behaviour:
- State:
  - pc[PC_W-1:0]
  - ir[7:0]
  - ir_valid: a 2-state FSM, RUN (1) / BUBBLE (0)
  - alt: alternate mode flag
- Reset (sync_reset=1 at an edge):
  - pc <= RESET_PC, ir <= 8'h00, ir_valid <= 0, alt <= 0.
  - While sync_reset is high, outputs are forced: reg_en=9'h010 so the computational unit clears r and sets r_eq_0; all other control outputs are 0.
- Fetch, every non-reset edge: ir <= pm_data, pc <= pc+1 (wraps FF->00), ir_valid <= 1. Jump handling below overrides this.
- Decode is combinational from ir. When ir_valid=0, reg_en=0, i_sel=0 and source_sel=0.
- Destination codes d: 0 x0, 1 x1, 2 y0, 3 y1, 4 o_reg (reg_en[8]), 5 m, 6 i, 7 dm (reg_en[7]).
- Source codes s map to source_sel 0..7: x0, x1, y0, y1, r, m, i, dm.
- Load, ir[7]=0:
  - d=ir[6:4], source_sel=8 (pm_data/immediate).
  - Enable the register for d.
- Move, ir[7:6]=10:
  - d=ir[5:3], s=ir[2:0], source_sel=s.
  - If s==d and d!=7: source_sel=9 (i_pins).
  - 8'hBF (d=s=7): toggles alt at the edge; reg_en=0.
- Indirect post-increment, load or move with d==7 or s==7 (excluding 8'hBF):
  - Also assert reg_en[6] with i_sel=1.
  - If d==6 there is no conflict (s=7, d=6): i_sel=0 and the data_bus write wins.
- ALU, ir[7:5]=110: x_sel=ir[4], y_sel=ir[3], reg_en[4]=1, ir_nibble carries the function.
- JMP, ir[7:4]=1110, and JNZ, ir[7:4]=1111 (ir[3:0] ignored):
  - The target byte is at the current pc, so pm_data holds the target.
  - JMP, or JNZ with r_eq_0=0 (taken): pc <= pm_data, ir_valid <= 0.
  - JNZ with r_eq_0=1 (not taken): pc <= pc+1 (skip the target byte), ir_valid <= 0.
  - In both cases the bubble prevents the target byte from executing.
  - Jumps assert no reg_en bits.
- alternate_function = alt, registered; it changes the cycle after 8'hBF executes.
- r_eq_0 is sampled in the cycle the JNZ is in ir; an ALU result written in the immediately preceding instruction is visible.
- Timing: one instruction per cycle in RUN; taken or untaken jumps cost 2 cycles.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode field constants (LOAD, MOVE, ALU, JMP, JNZ prefixes)
  - destination/source code localparams
  - source_sel codes 8 (PM) and 9 (IPINS)
  - reg_en bit indices
  - the ALT_TOGGLE=8'hBF constant
- One natural sub-module is instr_decode: purely combinational, ir and ir_valid in, control vector out. The top module keeps pc, ir, the FSM and alt.

Test Plan:
- Reset with pm[0]=8'h35: during reset reg_en=9'h010. First valid cycle after release: ir=8'h35, reg_en=9'h008, source_sel=8, ir_nibble=5.
- Move 8'h81 (x0<=x1): source_sel=1, reg_en=9'h001. Move 8'h80 (d=s=0): source_sel=9.
- Move 8'h87 (x0<=dm): source_sel=7, reg_en=9'h041, i_sel=1. Move 8'hB7 (i<=dm): reg_en=9'h040, i_sel=0.
- ALU 8'hD9: x_sel=1, y_sel=1, reg_en=9'h010, ir_nibble=9. Then 8'hBF: alternate_function goes 1 the next cycle; a second 8'hBF returns it to 0.
- JMP at pm[10]=8'hE0, pm[11]=8'h40: pc goes 11 -> 8'h40. One bubble with reg_en=0, then ir=pm[8'h40].
- JNZ at pm[20]=8'hF0, pm[21]=8'h80: with r_eq_0=0, next pc=8'h80. With r_eq_0=1, next pc=22. A bubble follows in both cases. Also assert sync_reset mid-bubble: pc returns to 0 and ir_valid=0.
